// File: rtl/instr_decode_queue.sv
// ---------------------------------------------------------------------------
// instr_decode_queue
//
// Instruction register and decoder with a DEPTH-entry FIFO in front of it.
// Fetched words are pushed from the memory read port and the head entry is
// decoded for the register file and control unit. Fetch may run ahead of
// execute. A branch or jump discards every queued word with one i_flush.
//
// Parameters
//   WIDTH  datapath width (>= 32); instructions are always i_Memdata[31:0]
//   DEPTH  queue entries (power of two, >= 2)
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_instrwrite   producer valid
//   o_ready        queue can accept a push
//   i_Memdata      fetched instruction word (upper WIDTH-32 bits ignored)
//   i_pop          consumer has used the head entry
//   i_flush        synchronous discard of all entries
//   i_regdst       destination select: 1 -> instr[15:11], 0 -> instr[20:16]
//   i_signext      immediate extension: 1 -> sign, 0 -> zero
//   o_valid        head entry present
//   o_RegA_addr    head instr[25:21]
//   o_RegB_addr    head instr[20:16]
//   o_RegD_addr    head destination register per i_regdst
//   o_op           head instr[31:26]
//   o_funct        head instr[5:0]
//   o_shamt        head instr[10:6]
//   o_Imm          extended head instr[15:0]
//   o_count        occupancy
//   o_overflow     sticky flag: a push was attempted while o_ready was low
//
// Handshake: a push happens on a rising edge where i_instrwrite && o_ready;
// a pop happens on a rising edge where i_pop && o_valid. Both o_ready and
// o_valid come from the registered count only, so neither depends on the
// opposite side's request in the same cycle. i_flush beats push and pop.
// ---------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_instrwrite,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_Memdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic                       i_regdst,
    input  logic                       i_signext,
    output logic                       o_valid,
    output logic [4:0]                 o_RegA_addr,
    output logic [4:0]                 o_RegB_addr,
    output logic [4:0]                 o_RegD_addr,
    output logic [5:0]                 o_op,
    output logic [5:0]                 o_funct,
    output logic [4:0]                 o_shamt,
    output logic [WIDTH-1:0]           o_Imm,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          push_en;
    logic          pop_en;
    logic          mem_we;
    logic [31:0]   mem_wdata;

    // Only the low 32 bits carry the instruction at any datapath width.
    generate
        if (WIDTH > 32) begin : g_unused_hi
            logic unused_mem_hi;
            assign unused_mem_hi = ^i_Memdata[WIDTH-1:32];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Handshake status from registered count
    // -----------------------------------------------------------------------
    always_comb begin
        o_ready = (count_q != FULL_CNT);
        o_valid = (count_q != '0);
        o_count = count_q;
        o_overflow = overflow_q;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        push_en    = i_instrwrite && o_ready;
        pop_en     = i_pop && o_valid;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_wdata  = i_Memdata[31:0];

        // A rejected push is recorded even in a flush cycle; the word is dropped.
        if (i_instrwrite && !o_ready) begin
            overflow_d = 1'b1;
        end

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage holds no reset; entries are qualified by count.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Decode of the head entry; live i_regdst / i_signext select fields.
    // -----------------------------------------------------------------------
    logic [31:0] head;

    always_comb begin
        head        = mem_q[rd_ptr_q];

        o_RegA_addr = '0;
        o_RegB_addr = '0;
        o_RegD_addr = '0;
        o_op        = '0;
        o_funct     = '0;
        o_shamt     = '0;
        o_Imm       = '0;

        if (o_valid) begin
            o_RegA_addr = head[25:21];
            o_RegB_addr = head[20:16];
            o_RegD_addr = i_regdst ? head[15:11] : head[20:16];
            o_op        = head[31:26];
            o_funct     = head[5:0];
            o_shamt     = head[10:6];
            if (i_signext) begin
                o_Imm = {{(WIDTH-16){head[15]}}, head[15:0]};
            end else begin
                o_Imm = {{(WIDTH-16){1'b0}}, head[15:0]};
            end
        end
    end

endmodule
